// File: rtl/cargo_request_scheduler_if.sv
// Request/target bus between the request source, the cargo scheduler and the movement control unit.
interface cargo_request_scheduler_if #(
  parameter int ANDAR_W = 2,
  parameter int PTR_W   = 2
);
  logic               req_valid;
  logic [ANDAR_W-1:0] req_origem;
  logic [ANDAR_W-1:0] req_destino;
  logic               req_ready;
  logic               req_erro;
  logic [ANDAR_W-1:0] andar_atual;
  logic               shift;
  logic               limpa;
  logic               tem_destino;
  logic [ANDAR_W-1:0] destino_atual;
  logic               sobe;
  logic               eh_origem;
  logic               chegou_destino;
  logic [PTR_W:0]     ocupacao;
  logic               cheio;
  logic               vazio;

  modport master (
    output req_valid, req_origem, req_destino, andar_atual, shift, limpa,
    input  req_ready, req_erro, tem_destino, destino_atual, sobe, eh_origem,
           chegou_destino, ocupacao, cheio, vazio
  );

  modport slave (
    input  req_valid, req_origem, req_destino, andar_atual, shift, limpa,
    output req_ready, req_erro, tem_destino, destino_atual, sobe, eh_origem,
           chegou_destino, ocupacao, cheio, vazio
  );
endinterface

// File: rtl/cargo_request_scheduler.sv
// Request FIFO presenting origin then destination floor of the head request; shift -> new target in 1 cycle.
// Backpressure: req_ready = !cheio. Optional CARGO_SCHED_DEDUP_EN drops requests already queued.
module cargo_request_scheduler #(
  parameter int ANDAR_W = 2,
  parameter int DEPTH   = 4,
  parameter int PTR_W   = 2
) (
  input logic                     clock,
  input logic                     reset,
  cargo_request_scheduler_if.slave bus
);

  typedef struct packed {
    logic [ANDAR_W-1:0] origem;
    logic [ANDAR_W-1:0] destino;
  } req_t;

  typedef enum logic {ORIGEM = 1'b0, DESTINO = 1'b1} fase_e;

  req_t            mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   ocup_q, ocup_d;
  fase_e            fase_q, fase_d;
  logic             erro_q, erro_d;

  req_t  req_in;
  req_t  head;
  logic  vazio, cheio;
  logic  accept, same_floor, dup_hit, push, pop, advance;

  assign req_in     = '{origem: bus.req_origem, destino: bus.req_destino};
  assign head       = mem_q[rd_ptr_q];
  assign vazio      = (ocup_q == '0);
  assign cheio      = (ocup_q == (PTR_W+1)'(DEPTH));
  assign accept     = bus.req_valid && !cheio;
  assign same_floor = (bus.req_origem == bus.req_destino);

`ifdef CARGO_SCHED_DEDUP_EN
  logic [DEPTH-1:0] hit;
  for (genvar g = 0; g < DEPTH; g++) begin : g_dup
    logic [PTR_W-1:0] off;
    // Slot distance from head; slots at or beyond ocupacao hold stale data.
    assign off    = PTR_W'(g) - rd_ptr_q;
    assign hit[g] = ({1'b0, off} < ocup_q) && (mem_q[g] == req_in);
  end
  assign dup_hit = |hit;
`else
  assign dup_hit = 1'b0;
`endif

  assign push    = accept && !same_floor && !dup_hit && !bus.limpa;
  assign advance = bus.shift && !vazio && (fase_q == ORIGEM);
  assign pop     = bus.shift && !vazio && (fase_q == DESTINO);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    ocup_d   = ocup_q;
    fase_d   = fase_q;
    erro_d   = accept && same_floor;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop) ocup_d = ocup_q + 1'b1;
    if (pop && !push) ocup_d = ocup_q - 1'b1;
    case (fase_q)
      ORIGEM:  if (advance) fase_d = DESTINO;
      DESTINO: if (pop)     fase_d = ORIGEM;
      default:              fase_d = ORIGEM;
    endcase
    if (bus.limpa) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      ocup_d   = '0;
      fase_d   = ORIGEM;
      erro_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      ocup_q   <= '0;
      fase_q   <= ORIGEM;
      erro_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      ocup_q   <= ocup_d;
      fase_q   <= fase_d;
      erro_q   <= erro_d;
    end
  end

  // Storage needs no reset: every read is qualified by ocupacao.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= req_in;
  end

  logic [ANDAR_W-1:0] alvo;
  assign alvo = vazio ? '0 : ((fase_q == ORIGEM) ? head.origem : head.destino);

  assign bus.req_ready      = !cheio;
  assign bus.req_erro       = erro_q;
  assign bus.tem_destino    = !vazio;
  assign bus.destino_atual  = alvo;
  assign bus.sobe           = (alvo > bus.andar_atual);
  assign bus.eh_origem      = vazio || (fase_q == ORIGEM);
  assign bus.chegou_destino = !vazio && (alvo == bus.andar_atual);
  assign bus.ocupacao       = ocup_q;
  assign bus.cheio          = cheio;
  assign bus.vazio          = vazio;

endmodule
